// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: default sizing and the
// bit positions of the individual hazard causes (useful for debug/trace).
package hazard_scoreboard_pkg;

   localparam int NREG_DEF    = 8;
   localparam int RA_W_DEF    = $clog2(NREG_DEF);
   localparam int MAXPEND_DEF = 3;

   // Hazard-cause bit indices within the internal hazard vector.
   localparam int HZ_SRC1  = 0;
   localparam int HZ_SRC2  = 1;
   localparam int HZ_WAW   = 2;
   localparam int HZ_FLAGR = 3;
   localparam int HZ_FLAGW = 4;
   localparam int HZ_LSU   = 5;
   localparam int HZ_N     = 6;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decoder / retire / status bundle for the hazard scoreboard.
// master = decoder+writeback side, slave = the scoreboard itself.
interface hazard_scoreboard_if
   import hazard_scoreboard_pkg::*;
#(
   parameter int NREG = NREG_DEF
);
   localparam int RA_W = $clog2(NREG);

   logic            ISSUE_VALID;
   logic            RD1_EN;
   logic            RD2_EN;
   logic [RA_W-1:0] RD1_ADDR;
   logic [RA_W-1:0] RD2_ADDR;
   logic            WR_EN;
   logic [RA_W-1:0] WR_ADDR;
   logic            FLAG_RD;
   logic            FLAG_WR;
   logic            LSU_USE;
   logic            RET_WR_EN;
   logic [RA_W-1:0] RET_WR_ADDR;
   logic            RET_FLAG;
   logic            RET_LSU;
   logic            FLUSH;
   logic            ISSUE_READY;
   logic            STALL;
   logic [NREG-1:0] BUSY;
   logic            FLAG_BUSY;
   logic            LSU_BUSY;
   logic            PEND_ERR;

   modport master (
      output ISSUE_VALID, RD1_EN, RD2_EN, RD1_ADDR, RD2_ADDR, WR_EN, WR_ADDR,
             FLAG_RD, FLAG_WR, LSU_USE, RET_WR_EN, RET_WR_ADDR, RET_FLAG,
             RET_LSU, FLUSH,
      input  ISSUE_READY, STALL, BUSY, FLAG_BUSY, LSU_BUSY, PEND_ERR
   );

   modport slave (
      input  ISSUE_VALID, RD1_EN, RD2_EN, RD1_ADDR, RD2_ADDR, WR_EN, WR_ADDR,
             FLAG_RD, FLAG_WR, LSU_USE, RET_WR_EN, RET_WR_ADDR, RET_FLAG,
             RET_LSU, FLUSH,
      output ISSUE_READY, STALL, BUSY, FLAG_BUSY, LSU_BUSY, PEND_ERR
   );

endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// sb_counter: saturating up/down in-flight counter. Simultaneous inc and
// dec cancel; clr wins over both and never reports an error. err_o pulses
// for a decrement at zero or an increment at MAX (count holds).
module sb_counter #(
   parameter int W   = 2,
   parameter int MAX = 3
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic dec_i,
   input  logic clr_i,
   output logic zero_o,
   output logic one_o,
   output logic full_o,
   output logic err_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count and error pulse.
   always_comb begin
      cnt_d = cnt_q;
      err_o = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !dec_i) begin
         if (cnt_q == W'(MAX)) err_o = 1'b1;
         else                  cnt_d = cnt_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0) err_o = 1'b1;
         else             cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);
   assign one_o  = (cnt_q == W'(1));
   assign full_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register / flag in-flight counters plus an LSU
// busy bit; stalls issue while any needed resource is unavailable.
// Optional feature macro: SCOREBOARD_BYPASS_EN (same-cycle retire release).
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NREG    = NREG_DEF,
   parameter int MAXPEND = MAXPEND_DEF
) (
   input logic                CLK,
   input logic                N_RST,
   hazard_scoreboard_if.slave sb
);

   localparam int RA_W  = $clog2(NREG);
   localparam int CNT_W = $clog2(MAXPEND + 1);

`ifdef SCOREBOARD_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [NREG-1:0] reg_inc, reg_dec, reg_zero, reg_one, reg_full, reg_err;
   logic [NREG-1:0] pend;
   logic            flag_zero, flag_one, flag_full, flag_err;
   logic            fpend, lsu_pend, accept;
   logic            lsu_busy_q, lsu_busy_d;
   logic            pend_err_q, pend_err_d;
   logic [HZ_N-1:0] hazard;

   // Per-register increment/decrement strobes and pending terms.
   // With bypass, "cnt > retiring" is expressed as nonzero and not
   // (exactly one outstanding and it retires now).
   always_comb begin
      reg_inc = '0;
      reg_dec = '0;
      pend    = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
         reg_inc[r] = accept && sb.WR_EN && (sb.WR_ADDR == RA_W'(r));
         reg_dec[r] = sb.RET_WR_EN && (sb.RET_WR_ADDR == RA_W'(r));
         pend[r]    = !reg_zero[r] && !(BYPASS && reg_one[r] && reg_dec[r]);
      end
   end

   assign fpend    = !flag_zero && !(BYPASS && flag_one && sb.RET_FLAG);
   assign lsu_pend = lsu_busy_q && !(BYPASS && sb.RET_LSU);

   // Hazard causes and issue acceptance.
   always_comb begin
      hazard           = '0;
      hazard[HZ_SRC1]  = sb.RD1_EN  && pend[sb.RD1_ADDR];
      hazard[HZ_SRC2]  = sb.RD2_EN  && pend[sb.RD2_ADDR];
      hazard[HZ_WAW]   = sb.WR_EN   && reg_full[sb.WR_ADDR];
      hazard[HZ_FLAGR] = sb.FLAG_RD && fpend;
      hazard[HZ_FLAGW] = sb.FLAG_WR && flag_full;
      hazard[HZ_LSU]   = sb.LSU_USE && lsu_pend;
   end

   assign sb.ISSUE_READY = ~|hazard;
   assign sb.STALL       = sb.ISSUE_VALID && !sb.ISSUE_READY;
   assign accept         = sb.ISSUE_VALID && sb.ISSUE_READY && !sb.FLUSH;

   for (genvar g = 0; g < NREG; g++) begin : g_reg_cnt
      sb_counter #(.W(CNT_W), .MAX(MAXPEND)) u_cnt (
         .clk_i  (CLK),
         .rst_ni (N_RST),
         .inc_i  (reg_inc[g]),
         .dec_i  (reg_dec[g]),
         .clr_i  (sb.FLUSH),
         .zero_o (reg_zero[g]),
         .one_o  (reg_one[g]),
         .full_o (reg_full[g]),
         .err_o  (reg_err[g])
      );
   end

   sb_counter #(.W(CNT_W), .MAX(MAXPEND)) u_flag_cnt (
      .clk_i  (CLK),
      .rst_ni (N_RST),
      .inc_i  (accept && sb.FLAG_WR),
      .dec_i  (sb.RET_FLAG),
      .clr_i  (sb.FLUSH),
      .zero_o (flag_zero),
      .one_o  (flag_one),
      .full_o (flag_full),
      .err_o  (flag_err)
   );

   // LSU busy next state (set wins over same-cycle completion) and sticky error.
   always_comb begin
      lsu_busy_d = lsu_busy_q;
      if (sb.FLUSH)                   lsu_busy_d = 1'b0;
      else if (accept && sb.LSU_USE)  lsu_busy_d = 1'b1;
      else if (sb.RET_LSU)            lsu_busy_d = 1'b0;
      pend_err_d = pend_err_q || (|reg_err) || flag_err;
   end

   // LSU busy and error registers.
   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         lsu_busy_q <= 1'b0;
         pend_err_q <= 1'b0;
      end else begin
         lsu_busy_q <= lsu_busy_d;
         pend_err_q <= pend_err_d;
      end
   end

   assign sb.BUSY      = ~reg_zero;
   assign sb.FLAG_BUSY = !flag_zero;
   assign sb.LSU_BUSY  = lsu_busy_q;
   assign sb.PEND_ERR  = pend_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus a
// randomized run against a counting reference model.
module tb_hazard_scoreboard;

   localparam int NREG    = 8;
   localparam int MAXPEND = 3;
`ifdef SCOREBOARD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   hazard_scoreboard_if #(.NREG(NREG)) bus ();

   hazard_scoreboard #(.NREG(NREG), .MAXPEND(MAXPEND)) dut (
      .CLK   (clk),
      .N_RST (n_rst),
      .sb    (bus.slave)
   );

   always #5 clk = ~clk;

   // reference model state
   int cnt_m [NREG];
   int fcnt_m;
   bit lsu_m;
   bit err_m;

   task automatic idle_inputs();
      bus.ISSUE_VALID = 0; bus.RD1_EN = 0; bus.RD2_EN = 0;
      bus.RD1_ADDR = '0; bus.RD2_ADDR = '0; bus.WR_EN = 0; bus.WR_ADDR = '0;
      bus.FLAG_RD = 0; bus.FLAG_WR = 0; bus.LSU_USE = 0;
      bus.RET_WR_EN = 0; bus.RET_WR_ADDR = '0; bus.RET_FLAG = 0;
      bus.RET_LSU = 0; bus.FLUSH = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      idle_inputs();
      n_rst = 0;
      repeat (2) @(posedge clk);
      #2 n_rst = 1;
   endtask

   task automatic test_reset();
      do_reset();
      bus.ISSUE_VALID = 1; bus.RD1_EN = 1; bus.RD1_ADDR = 3'd3;
      #1;
      checks++; if (bus.ISSUE_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ISSUE_READY); end
      checks++; if (bus.STALL !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.STALL); end
      checks++; if (bus.BUSY !== 8'h00) begin errors++; $display("FAIL reset_busy: got %h want 00", bus.BUSY); end
      checks++; if ({bus.FLAG_BUSY, bus.LSU_BUSY, bus.PEND_ERR} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.FLAG_BUSY, bus.LSU_BUSY, bus.PEND_ERR}); end
      // async reset discards pending state without a clock edge
      idle_inputs();
      bus.ISSUE_VALID = 1; bus.WR_EN = 1; bus.WR_ADDR = 3'd0; bus.LSU_USE = 1;
      tick();
      idle_inputs();
      checks++; if (bus.BUSY !== 8'h01 || bus.LSU_BUSY !== 1'b1) begin errors++; $display("FAIL async_pre: busy %h lsu %b want 01 1", bus.BUSY, bus.LSU_BUSY); end
      #1 n_rst = 0;
      #1;
      checks++; if (bus.BUSY !== 8'h00 || bus.LSU_BUSY !== 1'b0) begin errors++; $display("FAIL async_reset: busy %h lsu %b want 00 0", bus.BUSY, bus.LSU_BUSY); end
      #1 n_rst = 1;
   endtask

   task automatic test_raw();
      do_reset();
      bus.ISSUE_VALID = 1; bus.WR_EN = 1; bus.WR_ADDR = 3'd5;
      tick();
      bus.WR_EN = 0; bus.RD2_EN = 1; bus.RD2_ADDR = 3'd5;
      #1;
      checks++; if (bus.STALL !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", bus.STALL); end
      checks++; if (bus.BUSY !== 8'h20) begin errors++; $display("FAIL raw_busy: got %h want 20", bus.BUSY); end
      tick();
      checks++; if (bus.STALL !== 1'b1) begin errors++; $display("FAIL raw_hold: got %b want 1", bus.STALL); end
      bus.RET_WR_EN = 1; bus.RET_WR_ADDR = 3'd5;
      #1;
      checks++; if (bus.STALL !== !BYP) begin errors++; $display("FAIL raw_ret_cycle: got %b want %b", bus.STALL, !BYP); end
      tick();
      bus.RET_WR_EN = 0;
      #1;
      checks++; if (bus.STALL !== 1'b0 || bus.BUSY !== 8'h00) begin errors++; $display("FAIL raw_release: stall %b busy %h want 0 00", bus.STALL, bus.BUSY); end
   endtask

   task automatic test_waw();
      do_reset();
      bus.ISSUE_VALID = 1; bus.WR_EN = 1; bus.WR_ADDR = 3'd2;
      repeat (3) tick();
      #1;
      checks++; if (bus.STALL !== 1'b1) begin errors++; $display("FAIL waw_full: got %b want 1", bus.STALL); end
      tick();
      bus.RET_WR_EN = 1; bus.RET_WR_ADDR = 3'd2;
      tick();
      bus.RET_WR_EN = 0;
      #1;
      checks++; if (bus.STALL !== 1'b0) begin errors++; $display("FAIL waw_unblock: got %b want 0", bus.STALL); end
      tick();
      idle_inputs();
      checks++; if (bus.BUSY !== 8'h04 || bus.PEND_ERR !== 1'b0) begin errors++; $display("FAIL waw_busy: busy %h err %b want 04 0", bus.BUSY, bus.PEND_ERR); end
      // count must now be exactly 3: three retires clear it, a fourth errs
      bus.RET_WR_EN = 1; bus.RET_WR_ADDR = 3'd2;
      repeat (2) tick();
      checks++; if (bus.BUSY !== 8'h04) begin errors++; $display("FAIL waw_count: busy %h want 04", bus.BUSY); end
      tick();
      bus.RET_WR_EN = 0;
      checks++; if (bus.BUSY !== 8'h00 || bus.PEND_ERR !== 1'b0) begin errors++; $display("FAIL waw_drain: busy %h err %b want 00 0", bus.BUSY, bus.PEND_ERR); end
   endtask

   task automatic test_flag();
      do_reset();
      bus.ISSUE_VALID = 1; bus.FLAG_WR = 1;
      tick();
      bus.FLAG_WR = 0; bus.FLAG_RD = 1;
      #1;
      checks++; if (bus.STALL !== 1'b1 || bus.FLAG_BUSY !== 1'b1) begin errors++; $display("FAIL flag_raw: stall %b fbusy %b want 1 1", bus.STALL, bus.FLAG_BUSY); end
      bus.FLAG_RD = 0; bus.FLAG_WR = 1; bus.RET_FLAG = 1;
      tick();
      checks++; if (bus.FLAG_BUSY !== 1'b1) begin errors++; $display("FAIL flag_net: got %b want 1", bus.FLAG_BUSY); end
      bus.FLAG_WR = 0;
      tick();
      bus.RET_FLAG = 0;
      checks++; if (bus.FLAG_BUSY !== 1'b0 || bus.PEND_ERR !== 1'b0) begin errors++; $display("FAIL flag_drain: fbusy %b err %b want 0 0", bus.FLAG_BUSY, bus.PEND_ERR); end
   endtask

   task automatic test_lsu();
      do_reset();
      bus.ISSUE_VALID = 1; bus.LSU_USE = 1;
      tick();
      #1;
      checks++; if (bus.STALL !== 1'b1 || bus.LSU_BUSY !== 1'b1) begin errors++; $display("FAIL lsu_stall: stall %b busy %b want 1 1", bus.STALL, bus.LSU_BUSY); end
      bus.LSU_USE = 0; bus.RET_LSU = 1;
      tick();
      checks++; if (bus.LSU_BUSY !== 1'b0) begin errors++; $display("FAIL lsu_done: got %b want 0", bus.LSU_BUSY); end
      bus.LSU_USE = 1;
      tick();
      idle_inputs();
      checks++; if (bus.LSU_BUSY !== 1'b1) begin errors++; $display("FAIL lsu_set_wins: got %b want 1", bus.LSU_BUSY); end
   endtask

   task automatic test_flush();
      do_reset();
      bus.ISSUE_VALID = 1; bus.WR_EN = 1; bus.WR_ADDR = 3'd1; bus.FLAG_WR = 1; bus.LSU_USE = 1;
      tick();
      bus.FLAG_WR = 0; bus.LSU_USE = 0; bus.WR_ADDR = 3'd4;
      tick();
      checks++; if (bus.BUSY !== 8'h12 || bus.FLAG_BUSY !== 1'b1 || bus.LSU_BUSY !== 1'b1) begin errors++; $display("FAIL flush_pre: busy %h f %b l %b want 12 1 1", bus.BUSY, bus.FLAG_BUSY, bus.LSU_BUSY); end
      bus.WR_ADDR = 3'd6; bus.FLUSH = 1; bus.RET_WR_EN = 1; bus.RET_WR_ADDR = 3'd1;
      tick();
      idle_inputs();
      checks++; if (bus.BUSY !== 8'h00 || bus.FLAG_BUSY !== 1'b0 || bus.LSU_BUSY !== 1'b0 || bus.PEND_ERR !== 1'b0) begin errors++; $display("FAIL flush_clear: busy %h f %b l %b e %b want 00 0 0 0", bus.BUSY, bus.FLAG_BUSY, bus.LSU_BUSY, bus.PEND_ERR); end
      bus.RET_WR_EN = 1; bus.RET_WR_ADDR = 3'd1;
      tick();
      idle_inputs();
      tick();
      checks++; if (bus.PEND_ERR !== 1'b1 || bus.BUSY !== 8'h00) begin errors++; $display("FAIL late_retire: err %b busy %h want 1 00", bus.PEND_ERR, bus.BUSY); end
   endtask

   task automatic test_random();
      bit ready_e, acc, hz, bad;
      logic [NREG-1:0] busy_e;
      int n, ret_a;
      do_reset();
      for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
      fcnt_m = 0; lsu_m = 0; err_m = 0;
      for (int i = 0; i < 600; i++) begin
         bad = (i >= 450);
         bus.ISSUE_VALID = ($urandom_range(0, 3) != 0);
         bus.RD1_EN = $urandom_range(0, 1); bus.RD1_ADDR = 3'($urandom_range(0, NREG - 1));
         bus.RD2_EN = $urandom_range(0, 1); bus.RD2_ADDR = 3'($urandom_range(0, NREG - 1));
         bus.WR_EN = $urandom_range(0, 1);  bus.WR_ADDR = 3'($urandom_range(0, 3));
         bus.FLAG_RD = ($urandom_range(0, 3) == 0); bus.FLAG_WR = $urandom_range(0, 1);
         bus.LSU_USE = ($urandom_range(0, 2) == 0);
         ret_a = $urandom_range(0, 3);
         bus.RET_WR_ADDR = 3'(ret_a);
         bus.RET_WR_EN = $urandom_range(0, 1) && (bad || cnt_m[ret_a] > 0);
         bus.RET_FLAG = ($urandom_range(0, 2) == 0) && (bad || fcnt_m > 0);
         bus.RET_LSU = $urandom_range(0, 1) && (bad || lsu_m);
         bus.FLUSH = ($urandom_range(0, 39) == 0);
         // expected issue decision from outstanding counts
         hz = 0;
         if (bus.RD1_EN && cnt_m[bus.RD1_ADDR] - int'(BYP && bus.RET_WR_EN && bus.RET_WR_ADDR == bus.RD1_ADDR) > 0) hz = 1;
         if (bus.RD2_EN && cnt_m[bus.RD2_ADDR] - int'(BYP && bus.RET_WR_EN && bus.RET_WR_ADDR == bus.RD2_ADDR) > 0) hz = 1;
         if (bus.WR_EN && cnt_m[bus.WR_ADDR] == MAXPEND) hz = 1;
         if (bus.FLAG_RD && fcnt_m - int'(BYP && bus.RET_FLAG) > 0) hz = 1;
         if (bus.FLAG_WR && fcnt_m == MAXPEND) hz = 1;
         if (bus.LSU_USE && lsu_m && !(BYP && bus.RET_LSU)) hz = 1;
         ready_e = !hz;
         for (int r = 0; r < NREG; r++) busy_e[r] = (cnt_m[r] != 0);
         #1;
         checks++; if (bus.ISSUE_READY !== ready_e || bus.STALL !== (bus.ISSUE_VALID && !ready_e)) begin errors++; $display("FAIL rnd_issue[%0d]: ready %b stall %b want %b %b", i, bus.ISSUE_READY, bus.STALL, ready_e, bus.ISSUE_VALID && !ready_e); end
         checks++; if (bus.BUSY !== busy_e || bus.FLAG_BUSY !== (fcnt_m != 0) || bus.LSU_BUSY !== lsu_m || bus.PEND_ERR !== err_m) begin errors++; $display("FAIL rnd_state[%0d]: busy %h f %b l %b e %b want %h %b %b %b", i, bus.BUSY, bus.FLAG_BUSY, bus.LSU_BUSY, bus.PEND_ERR, busy_e, fcnt_m != 0, lsu_m, err_m); end
         // advance the model
         acc = bus.ISSUE_VALID && ready_e && !bus.FLUSH;
         if (bus.FLUSH) begin
            for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
            fcnt_m = 0; lsu_m = 0;
         end else begin
            for (int r = 0; r < NREG; r++) begin
               n = cnt_m[r] + int'(acc && bus.WR_EN && bus.WR_ADDR == r) - int'(bus.RET_WR_EN && bus.RET_WR_ADDR == r);
               if (n < 0) begin n = 0; err_m = 1; end
               if (n > MAXPEND) begin n = MAXPEND; err_m = 1; end
               cnt_m[r] = n;
            end
            n = fcnt_m + int'(acc && bus.FLAG_WR) - int'(bus.RET_FLAG);
            if (n < 0) begin n = 0; err_m = 1; end
            if (n > MAXPEND) begin n = MAXPEND; err_m = 1; end
            fcnt_m = n;
            if (acc && bus.LSU_USE) lsu_m = 1;
            else if (bus.RET_LSU)   lsu_m = 0;
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_raw();
      test_waw();
      test_flag();
      test_lsu();
      test_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register/flag/LSU hazard scoreboard between the instruction decoder and the ALU/LSU issue stage. It generalises the per-register "pending write" chain into per-register in-flight counters, so several writes to one register may be outstanding. It adds explicit retire and flush inputs, and asserts stall while any source, destination, flag or LSU resource is unavailable.

## Interface
Parameters:
- NREG, 8, number of architectural registers; must be a power of two, at least 2.
- RA_W, $clog2(NREG), register address width; derived, not overridden.
- MAXPEND, 3, maximum in-flight writes per register and for the flag; range 1..15.
- CNT_W, $clog2(MAXPEND+1), counter width; derived.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- N_RST  in  1  reset; asynchronous, active-low.
- ISSUE_VALID  in  1  decoder presents an instruction this cycle.
- RD1_EN, RD2_EN  in  1  source operand 1 / 2 is read.
- RD1_ADDR, RD2_ADDR  in  RA_W  source register numbers.
- WR_EN  in  1  instruction writes a register.
- WR_ADDR  in  RA_W  destination register.
- FLAG_RD  in  1  instruction reads the condition flags (conditional branch).
- FLAG_WR  in  1  instruction writes the flags (ALU/shift/compare).
- LSU_USE  in  1  instruction occupies the LSU (load, store, push, pop, call, return).
- RET_WR_EN  in  1  a register write retires at writeback.
- RET_WR_ADDR  in  RA_W  retiring register.
- RET_FLAG  in  1  a flag write retires.
- RET_LSU  in  1  the outstanding LSU operation completes.
- FLUSH  in  1  synchronous clear of all pending state (pipeline kill).
- ISSUE_READY  out  1  no hazard; the instruction is accepted if ISSUE_VALID.
- STALL  out  1  ISSUE_VALID & ~ISSUE_READY.
- BUSY  out  NREG  bit r set while cnt[r] != 0.
- FLAG_BUSY  out  1  flag counter != 0.
- LSU_BUSY  out  1  an LSU operation is outstanding.
- PEND_ERR  out  1  sticky error: retire against a zero count, or overflow.

## Operation
- State: cnt[r] for each register (CNT_W bits), fcnt for the flags (CNT_W bits), and the lsu_busy bit.
- Hazard terms:
  - RD1_EN & pend(RD1_ADDR)
  - RD2_EN & pend(RD2_ADDR)
  - WR_EN & (cnt[WR_ADDR]==MAXPEND)
  - FLAG_RD & fpend
  - FLAG_WR & (fcnt==MAXPEND)
  - LSU_USE & lsu_pend
- ISSUE_READY = ~|hazard terms.
- Accept = ISSUE_VALID & ISSUE_READY & ~FLUSH.
- On accept:
  - cnt[WR_ADDR] increments if WR_EN.
  - fcnt increments if FLAG_WR.
  - lsu_busy is set if LSU_USE.
- On retire:
  - cnt[RET_WR_ADDR] decrements if RET_WR_EN.
  - fcnt decrements if RET_FLAG.
  - lsu_busy clears if RET_LSU.
- Same-cycle accept and retire on the same counter: net unchanged. Same-cycle LSU set and clear: set wins.
- Retire against a zero count: the counter holds at 0 and PEND_ERR is set.
- Increment at MAXPEND cannot occur, because issue is blocked. A defensive check sets PEND_ERR and saturates.
- FLUSH: next edge all counters go to 0 and lsu_busy to 0; accept is suppressed; retires in the same cycle are ignored without error.
- After FLUSH, late retires of killed instructions must not be presented; if they are, PEND_ERR is flagged.
- PEND_ERR clears only on reset.

## Timing
- ISSUE_READY and STALL are combinational from registered state and the current-cycle inputs.
- Counter updates are visible one cycle after accept or retire.
- A register retiring in cycle N unblocks a reader in cycle N+1 (no bypass), or in cycle N itself (see Configuration).
- Reset values: all cnt, fcnt and lsu_busy are 0. Outputs: BUSY=0, FLAG_BUSY=0, LSU_BUSY=0, PEND_ERR=0, ISSUE_READY=1, STALL=0.
- Reset assertion mid-operation discards all pending state immediately (asynchronous).

## Configuration
- SCOREBOARD_BYPASS_EN defined:
  - pend(r) = cnt[r] > (RET_WR_EN & RET_WR_ADDR==r).
  - fpend = fcnt > RET_FLAG.
  - lsu_pend = lsu_busy & ~RET_LSU.
  - A retire in cycle N releases a dependent issue in cycle N.
- SCOREBOARD_BYPASS_EN undefined: pend(r) = cnt[r]!=0, fpend = fcnt!=0, lsu_pend = lsu_busy. Releases happen one cycle later.
- BUSY, FLAG_BUSY and LSU_BUSY always reflect registered state in both builds.

## Structure
- Shared package: NREG default, RA_W, MAXPEND default, and the hazard-cause bit indices (SRC1, SRC2, WAW, FLAGR, FLAGW, LSU) for debug/trace.
- Sub-module sb_counter: one up/down saturating counter with inc, dec, clr, err-out and zero/full flags.
  - Instanced NREG times for registers, plus once for the flags.
  - lsu_busy is a plain flop in the top level.

## Test plan
- Reset, then ISSUE_VALID with RD1_ADDR=3 -> ISSUE_READY=1, BUSY=0.
- Issue WR_ADDR=5, then next cycle RD2_ADDR=5 -> STALL=1 until RET_WR_ADDR=5. Release in that same cycle with bypass, the cycle after without.
- Three accepted writes to r2 with MAXPEND=3 -> a fourth WR_ADDR=2 stalls. A single retire to r2 unblocks it, and BUSY[2] stays 1.
- FLAG_WR issue followed by FLAG_RD -> STALL until RET_FLAG. Simultaneous accept (FLAG_WR) and RET_FLAG leaves fcnt unchanged.
- LSU_USE accepted, then LSU_USE again -> stall. RET_LSU and a new accept in the same cycle leave LSU_BUSY=1.
- Pending r1, r4, flags and LSU, then FLUSH -> next cycle all BUSY=0 and PEND_ERR=0. A later RET_WR_ADDR=1 sets PEND_ERR=1.
